// File: rtl/control_unit_mc.sv
// ----------------------------------------------------------------------------
// control_unit_mc
//
// Main control unit for a 5-stage RISC-V pipeline. It decodes the ID-stage
// opcode/funct7 into datapath controls, separating MUL (funct7 = 0000001)
// from ordinary R-type. While a multi-cycle multiply is in flight it stalls
// PC/IF-ID and turns the ID/EX controls into bubbles. It also flushes IF on
// taken branches and JAL, and counts stall cycles.
//
// Parameters
//   MUL_LATENCY  multiplier latency in cycles (1..16)
//   CNT_W        width of the stall performance counter
//
// Ports
//   clk           clock, rising edge
//   arst          asynchronous active-high reset
//   id_valid      ID stage holds a valid instruction
//   opcode        ID instruction opcode[6:0]
//   funct7        ID instruction funct7
//   branch_taken  branch comparison result for the ID instruction
//   alu_op        00 add, 01 sub, 10 R-type, 11 mul
//   alu_src, mem_2_reg, mem_read, mem_write, reg_write, branch, jump
//                 datapath controls
//   if_flush      squash the IF/ID instruction
//   stall         hold PC and IF/ID
//   mul_start     one-cycle pulse launching the multiplier
//   mul_busy      multiplier sequencer is not idle
//   stall_count   saturating count of cycles with stall = 1
// ----------------------------------------------------------------------------
module control_unit_mc #(
    parameter int MUL_LATENCY = 4,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             id_valid,
    input  logic [6:0]       opcode,
    input  logic [6:0]       funct7,
    input  logic             branch_taken,
    output logic [1:0]       alu_op,
    output logic             alu_src,
    output logic             mem_2_reg,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             branch,
    output logic             jump,
    output logic             if_flush,
    output logic             stall,
    output logic             mul_start,
    output logic             mul_busy,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] F7_MUL    = 7'b0000001;

    // The counter only needs to hold MUL_LATENCY-2; keep at least one bit so
    // the vector is legal for the short latencies.
    localparam int CNT_BITS = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY) : 1;
    localparam logic [CNT_BITS-1:0] CNT_LOAD =
        CNT_BITS'((MUL_LATENCY > 1) ? (MUL_LATENCY - 2) : 0);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t              state_reg, state_next;
    logic [CNT_BITS-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0]    stall_count_reg;
    logic                issue;
    logic                mul_issue;

    // Stall derives straight from the state register, so an asynchronous
    // reset drops it without waiting for a clock edge.
    assign stall    = (state_reg == BUSY);
    assign mul_busy = (state_reg == BUSY);
    assign issue    = id_valid && !stall;
    assign mul_issue = issue && (opcode == OP_RTYPE) && (funct7 == F7_MUL);

    // ------------------------------------------------------------------
    // Combinational decode; a bubble (all zeros) whenever nothing issues.
    // ------------------------------------------------------------------
    always_comb begin
        alu_op    = 2'b00;
        alu_src   = 1'b0;
        mem_2_reg = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        branch    = 1'b0;
        jump      = 1'b0;
        if_flush  = 1'b0;
        if (issue) begin
            case (opcode)
                OP_RTYPE: begin
                    reg_write = 1'b1;
                    alu_op    = (funct7 == F7_MUL) ? 2'b11 : 2'b10;
                end
                OP_IALU: begin
                    alu_src   = 1'b1;
                    reg_write = 1'b1;
                end
                OP_BRANCH: begin
                    branch   = 1'b1;
                    alu_op   = 2'b01;
                    if_flush = branch_taken;
                end
                OP_JAL: begin
                    jump     = 1'b1;
                    if_flush = 1'b1;
                end
                OP_LOAD: begin
                    alu_src   = 1'b1;
                    mem_2_reg = 1'b1;
                    mem_read  = 1'b1;
                    reg_write = 1'b1;
                end
                OP_STORE: begin
                    alu_src   = 1'b1;
                    mem_write = 1'b1;
                end
                default: alu_op = 2'b10;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Multiplier sequencer: next state and start pulse.
    // mul_start can only fire from IDLE, which serialises back-to-back MULs:
    // the second one waits in ID behind the stall and issues afterwards.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        mul_start  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (mul_issue) begin
                    mul_start = 1'b1;
                    // A single-cycle multiplier never needs a stall.
                    if (MUL_LATENCY > 1) begin
                        state_next = BUSY;
                        cnt_next   = CNT_LOAD;
                    end
                end
            end
            BUSY: begin
                if (cnt_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            stall_count_reg <= '0;
        end else if (stall && (stall_count_reg != {CNT_W{1'b1}})) begin
            stall_count_reg <= stall_count_reg + 1'b1;
        end
    end

    assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_control_unit_mc.sv
// ----------------------------------------------------------------------------
// tb_control_unit_mc
//
// Three instances share one stimulus stream: latency 4 (32-bit counter),
// latency 1, and latency 4 with a 2-bit counter to exercise saturation.
// Expected outputs come from a behavioural model that tracks, per instance,
// how many stall cycles remain and how many stall cycles have elapsed.
// ----------------------------------------------------------------------------
module tb_control_unit_mc;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_B  = 7'b1100011;
    localparam logic [6:0] OP_J  = 7'b1101111;
    localparam logic [6:0] OP_L  = 7'b0000011;
    localparam logic [6:0] OP_S  = 7'b0100011;
    localparam logic [6:0] OP_0  = 7'b0000000;
    localparam logic [6:0] F_MUL = 7'b0000001;

    logic       clk = 1'b0;
    logic       arst = 1'b1;
    logic       v = 1'b0;
    logic [6:0] op = 7'd0;
    logic [6:0] f7 = 7'd0;
    logic       bt = 1'b0;

    int tests = 0;
    int fails = 0;

    // Model state
    int      rem4 = 0;
    int      rem1 = 0;
    longint  cnt4 = 0;
    longint  cnt1 = 0;

    always #5 clk = ~clk;

    // ---------------- DUT instances ----------------
    logic [1:0]  a_aluop, b_aluop, c_aluop;
    logic        a_src, a_m2r, a_mr, a_mw, a_rw, a_br, a_j, a_fl, a_st, a_ms, a_mb;
    logic        b_src, b_m2r, b_mr, b_mw, b_rw, b_br, b_j, b_fl, b_st, b_ms, b_mb;
    logic        c_src, c_m2r, c_mr, c_mw, c_rw, c_br, c_j, c_fl, c_st, c_ms, c_mb;
    logic [31:0] a_cnt, b_cnt;
    logic [1:0]  c_cnt;

    control_unit_mc #(.MUL_LATENCY(4), .CNT_W(32)) dut4 (
        .clk(clk), .arst(arst), .id_valid(v), .opcode(op), .funct7(f7),
        .branch_taken(bt), .alu_op(a_aluop), .alu_src(a_src),
        .mem_2_reg(a_m2r), .mem_read(a_mr), .mem_write(a_mw),
        .reg_write(a_rw), .branch(a_br), .jump(a_j), .if_flush(a_fl),
        .stall(a_st), .mul_start(a_ms), .mul_busy(a_mb), .stall_count(a_cnt));

    control_unit_mc #(.MUL_LATENCY(1), .CNT_W(32)) dut1 (
        .clk(clk), .arst(arst), .id_valid(v), .opcode(op), .funct7(f7),
        .branch_taken(bt), .alu_op(b_aluop), .alu_src(b_src),
        .mem_2_reg(b_m2r), .mem_read(b_mr), .mem_write(b_mw),
        .reg_write(b_rw), .branch(b_br), .jump(b_j), .if_flush(b_fl),
        .stall(b_st), .mul_start(b_ms), .mul_busy(b_mb), .stall_count(b_cnt));

    control_unit_mc #(.MUL_LATENCY(4), .CNT_W(2)) dut_sat (
        .clk(clk), .arst(arst), .id_valid(v), .opcode(op), .funct7(f7),
        .branch_taken(bt), .alu_op(c_aluop), .alu_src(c_src),
        .mem_2_reg(c_m2r), .mem_read(c_mr), .mem_write(c_mw),
        .reg_write(c_rw), .branch(c_br), .jump(c_j), .if_flush(c_fl),
        .stall(c_st), .mul_start(c_ms), .mul_busy(c_mb), .stall_count(c_cnt));

    // Bundle: {alu_op, alu_src, mem_2_reg, mem_read, mem_write, reg_write,
    //          branch, jump, if_flush, stall, mul_start, mul_busy}
    wire [12:0] obs_a = {a_aluop, a_src, a_m2r, a_mr, a_mw, a_rw, a_br, a_j, a_fl, a_st, a_ms, a_mb};
    wire [12:0] obs_b = {b_aluop, b_src, b_m2r, b_mr, b_mw, b_rw, b_br, b_j, b_fl, b_st, b_ms, b_mb};
    wire [12:0] obs_c = {c_aluop, c_src, c_m2r, c_mr, c_mw, c_rw, c_br, c_j, c_fl, c_st, c_ms, c_mb};

    // Instruction-table decode: {alu_op, src, m2r, mr, mw, rw, br, j}
    function automatic logic [8:0] table_decode(input logic [6:0] o, input logic [6:0] f);
        case (o)
            OP_R:    return (f == F_MUL) ? 9'b11_0000100 : 9'b10_0000100;
            OP_I:    return 9'b00_1000100;
            OP_B:    return 9'b01_0000010;
            OP_J:    return 9'b00_0000001;
            OP_L:    return 9'b00_1110100;
            OP_S:    return 9'b00_1001000;
            default: return 9'b10_0000000;
        endcase
    endfunction

    // Expected bundle given the number of stall cycles still owed.
    function automatic logic [12:0] expected(input int rem);
        logic       stl, iss, ismul, fl;
        logic [8:0] ctl;
        stl   = (rem > 0);
        iss   = v && !stl;
        ismul = (op == OP_R) && (f7 == F_MUL);
        ctl   = iss ? table_decode(op, f7) : 9'd0;
        fl    = iss && (((op == OP_B) && bt) || (op == OP_J));
        return {ctl, fl, stl, iss && ismul, stl};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        longint sat;
        sat = (cnt4 > 3) ? 3 : cnt4;
        check({tag, "/lat4"},  32'(obs_a), 32'(expected(rem4)));
        check({tag, "/lat1"},  32'(obs_b), 32'(expected(rem1)));
        check({tag, "/sat"},   32'(obs_c), 32'(expected(rem4)));
        check({tag, "/cnt4"},  a_cnt, cnt4[31:0]);
        check({tag, "/cnt1"},  b_cnt, cnt1[31:0]);
        check({tag, "/cntsat"}, 32'(c_cnt), sat[31:0]);
    endtask

    // Advance one model per clock edge.
    task automatic model_edge(inout int rem, inout longint cnt, input int lat);
        if (rem > 0) begin
            rem--;
            cnt++;
        end else if (v && (op == OP_R) && (f7 == F_MUL)) begin
            rem = lat - 1;
        end
    endtask

    // One clock cycle: drive at negedge, check before the rising edge.
    task automatic cycle(input logic iv, input logic [6:0] iop, input logic [6:0] if7,
                         input logic ibt, input string tag);
        @(negedge clk);
        v = iv; op = iop; f7 = if7; bt = ibt;
        #1;
        check_all(tag);
        $display("[TB] %s v=%0b op=%b f7=%b bt=%0b stall=%0b start=%0b cnt=%0d",
                 tag, v, op, f7, bt, a_st, a_ms, a_cnt);
        @(posedge clk);
        model_edge(rem4, cnt4, 4);
        model_edge(rem1, cnt1, 1);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        v = 1'b0;
        arst = 1'b1;
        #1;
        rem4 = 0; rem1 = 0; cnt4 = 0; cnt1 = 0;
        check_all(tag);
        #1;
        arst = 1'b0;
    endtask

    logic [6:0] op_list [8];

    initial begin
        op_list = '{OP_R, OP_I, OP_B, OP_J, OP_L, OP_S, OP_0, OP_R};

        // Reset state
        do_reset("reset");

        // Decode sweep, each opcode with id_valid low then high
        for (int i = 0; i < 7; i++) begin
            cycle(1'b0, op_list[i], 7'd0, 1'b1, "sweep_v0");
            cycle(1'b1, op_list[i], 7'd0, 1'b1, "sweep_v1");
        end

        // Single MUL followed by ADD
        do_reset("rst_single");
        cycle(1'b1, OP_R, F_MUL, 1'b0, "mul_T");
        for (int i = 0; i < 4; i++) cycle(1'b1, OP_R, 7'd0, 1'b0, "add_after_mul");
        check("single_cnt3", a_cnt, 32'd3);

        // Back-to-back MULs
        do_reset("rst_b2b");
        for (int i = 0; i < 5; i++) cycle(1'b1, OP_R, F_MUL, 1'b0, "mul_b2b");
        for (int i = 0; i < 4; i++) cycle(1'b1, OP_R, 7'd0, 1'b0, "add_b2b");
        check("b2b_cnt6", a_cnt, 32'd6);
        check("b2b_sat3", 32'(c_cnt), 32'd3);
        check("lat1_cnt0", b_cnt, 32'd0);

        // Taken / not-taken branch held behind a MUL
        for (int t = 1; t >= 0; t--) begin
            do_reset("rst_br");
            cycle(1'b1, OP_R, F_MUL, 1'b0, "mul_br");
            for (int i = 0; i < 4; i++) cycle(1'b1, OP_B, 7'd0, t[0], "branch_behind");
            cycle(1'b1, OP_J, 7'd0, 1'b0, "jal");
        end

        // Async reset mid-BUSY at T+2
        do_reset("rst_mid");
        cycle(1'b1, OP_R, F_MUL, 1'b0, "mul_mid");
        cycle(1'b0, OP_0, 7'd0, 1'b0, "busy_T1");
        @(negedge clk);
        v = 1'b0;
        #1;
        check("busy_T2_stall", 32'(a_st), 32'd1);
        arst = 1'b1;
        #1;
        rem4 = 0; rem1 = 0; cnt4 = 0; cnt1 = 0;
        check("arst_stall", 32'(a_st), 32'd0);
        check("arst_busy", 32'(a_mb), 32'd0);
        check("arst_cnt", a_cnt, 32'd0);
        #1;
        arst = 1'b0;
        cycle(1'b1, OP_R, F_MUL, 1'b0, "mul_after_rst");
        for (int i = 0; i < 4; i++) cycle(1'b1, OP_L, 7'd0, 1'b0, "load_after");

        // Randomised stream
        for (int i = 0; i < 400; i++) begin
            int         idx;
            logic [6:0] rop, rf7;
            idx = $urandom_range(0, 8);
            rop = (idx == 8) ? 7'($urandom) : op_list[idx];
            rf7 = ($urandom_range(0, 2) == 0) ? F_MUL : 7'($urandom);
            cycle(1'($urandom_range(0, 3) != 0), rop, rf7, 1'($urandom), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
